// File: rtl/vga_sync_monitor.sv
// Passive VGA receiver: recovers pixel coordinates, checks sync timing, tracks lock and probes one pixel.
// Optional per-frame CRC-16-CCITT of active pixels when VGA_MON_CRC_EN is defined; otherwise frame_crc is tied to 0.
module vga_sync_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  input  logic        err_clear,
  output logic        locked,
  output logic        rx_active,
  output logic [9:0]  rx_hpos,
  output logic [9:0]  rx_vpos,
  output logic [2:0]  probe_rgb,
  output logic        probe_valid,
  output logic [15:0] frame_count,
  output logic        err_line,
  output logic        err_frame,
  output logic [15:0] frame_crc
);

  localparam logic [9:0] H_START     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END       = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START     = 10'(V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_END       = 10'(V_SYNC + V_BACK - 1 + V_ACTIVE);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [3:0] GOOD_NEEDED = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        tracking;
  logic        hs_q, hs_d, vs_q, vs_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [2:0]  rgb_q, rgb_d, rgb_d2_q, rgb_d2_d, probe_rgb_q, probe_rgb_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0]  probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic [9:0]  rx_hpos_q, rx_hpos_d, rx_vpos_q, rx_vpos_d;
  logic        vs_pend_q, vs_pend_d, rx_active_q, rx_active_d, probe_valid_q, probe_valid_d;
  logic        err_line_q, err_line_d, err_frame_q, err_frame_d;
  logic [3:0]  good_q, good_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        hs_fall, hs_rise, vs_fall, vs_rise, boundary;
  logic        line_err, frame_err, frame_good, in_win, probe_hit;

  assign hs_fall  = hs_prev_q & ~hs_q;
  assign hs_rise  = ~hs_prev_q & hs_q;
  assign vs_fall  = vs_prev_q & ~vs_q;
  assign vs_rise  = ~vs_prev_q & vs_q;
  assign boundary = hs_fall & vs_pend_q;

  always_comb begin
    hs_d      = hsync;
    vs_d      = vsync;
    rgb_d     = rgb;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    rgb_d2_d  = rgb_q;
    h_cnt_d   = hs_fall ? 10'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1);
    v_cnt_d   = boundary ? 10'd0 : (hs_fall ? v_cnt_q + 10'd1 : v_cnt_q);
    vs_pend_d = (vs_pend_q & ~boundary) | vs_fall;
    line_err  = (hs_fall && h_cnt_q != H_LAST) || (hs_rise && h_cnt_q != H_SYNC_LAST) ||
                (!hs_fall && h_cnt_q == CNT_MAX - 10'd1);
    // vsync rises together with an hsync fall, so compare against the post-increment line count
    frame_err = (boundary && v_cnt_q != V_LAST) || (vs_rise && v_cnt_d != V_SYNC_LAST);
    frame_good = boundary & ~line_err & ~frame_err;

    good_d = good_q;
    if (state_q == SEARCH) good_d = 4'd0;
    else if (state_q == TRACK && frame_good) good_d = good_q + 4'd1;

    err_line_d    = (err_line_q & ~err_clear) | (line_err & tracking);
    err_frame_d   = (err_frame_q & ~err_clear) | (frame_err & tracking);
    frame_count_d = (locked && frame_good) ? frame_count_q + 16'd1 : frame_count_q;
    probe_x_d     = boundary ? probe_x : probe_x_q;
    probe_y_d     = boundary ? probe_y : probe_y_q;

    // h_cnt_d/v_cnt_d line up with the pixel currently held in rgb_q
    in_win      = (h_cnt_d >= H_START) && (h_cnt_d < H_END) && (v_cnt_d >= V_START) && (v_cnt_d < V_END);
    rx_active_d = in_win;
    rx_hpos_d   = in_win ? h_cnt_d - H_START : 10'd0;
    rx_vpos_d   = in_win ? v_cnt_d - V_START : 10'd0;

    probe_hit     = locked && rx_active_q && rx_hpos_q == probe_x_q && rx_vpos_q == probe_y_q;
    probe_valid_d = probe_hit;
    probe_rgb_d   = probe_hit ? rgb_d2_q : probe_rgb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1; vs_q <= 1'b1; hs_prev_q <= 1'b1; vs_prev_q <= 1'b1;
      rgb_q <= '0; rgb_d2_q <= '0; probe_rgb_q <= '0;
      h_cnt_q <= '0; v_cnt_q <= '0; vs_pend_q <= 1'b0; good_q <= '0;
      probe_x_q <= '0; probe_y_q <= '0;
      rx_active_q <= 1'b0; rx_hpos_q <= '0; rx_vpos_q <= '0; probe_valid_q <= 1'b0;
      err_line_q <= 1'b0; err_frame_q <= 1'b0; frame_count_q <= '0;
    end else begin
      hs_q <= hs_d; vs_q <= vs_d; hs_prev_q <= hs_prev_d; vs_prev_q <= vs_prev_d;
      rgb_q <= rgb_d; rgb_d2_q <= rgb_d2_d; probe_rgb_q <= probe_rgb_d;
      h_cnt_q <= h_cnt_d; v_cnt_q <= v_cnt_d; vs_pend_q <= vs_pend_d; good_q <= good_d;
      probe_x_q <= probe_x_d; probe_y_q <= probe_y_d;
      rx_active_q <= rx_active_d; rx_hpos_q <= rx_hpos_d; rx_vpos_q <= rx_vpos_d;
      probe_valid_q <= probe_valid_d;
      err_line_q <= err_line_d; err_frame_q <= err_frame_d; frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (boundary) state_d = TRACK;
      TRACK:   if (line_err || frame_err) state_d = SEARCH;
               else if (frame_good && (good_q + 4'd1) == GOOD_NEEDED) state_d = LOCKED;
      LOCKED:  if (line_err || frame_err) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked   = (state_q == LOCKED);
    tracking = (state_q != SEARCH);
  end

  assign rx_active   = rx_active_q;
  assign rx_hpos     = rx_hpos_q;
  assign rx_vpos     = rx_vpos_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
  assign frame_count = frame_count_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction

  // rx_active_q and rgb_d2_q are the same pixel; frame boundaries fall in blanking
  always_comb begin
    crc_acc_d   = rx_active_q ? crc16_byte(crc_acc_q, {5'b00000, rgb_d2_q}) : crc_acc_q;
    frame_crc_d = frame_crc_q;
    if (boundary) begin
      frame_crc_d = crc_acc_d;
      crc_acc_d   = 16'hFFFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = '0;
`endif

endmodule
